vec_mem_sequencer: RTL and testbench
====================================

VEC_MEM_SEQUENCER -- requirements
Module: vec_mem_sequencer

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector register width in bits; legal values are multiples of 32.
REQ-002 SHALL have parameter VREG_AW, default 5, vector register index width.
REQ-003 SHALL use one clock and an asynchronous active-low reset: port clk (input, 1, rising-edge clock), then port rst_n (input, 1, asynchronous active-low reset).
REQ-004 SHALL have start (input, 1): issue pulse from decode for a VLD/VST.
REQ-005 SHALL have is_load (input, 1): 1=VLD, 0=VST, sampled at start.
REQ-006 SHALL have base_addr (input, 32): rs1 value, sampled at start.
REQ-007 SHALL have stride (input, 32): rs2 byte stride, sampled at start; present only under VEC_STRIDE_EN.
REQ-008 SHALL have vd (input, VREG_AW): destination vector register index, sampled at start.
REQ-009 SHALL have vs_data (input, VLEN): store source, sampled at start.
REQ-010 SHALL have scalar_req, scalar_we (input, 1 each), scalar_addr, scalar_wdata, scalar_mask (input, 32 each): scalar LSU request.
REQ-011 SHALL have mem_re, mem_we (output, 1 each), mem_addr, mem_wdata, mem_mask (output, 32 each): shared data-memory port.
REQ-012 SHALL have mem_rdata (input, 32) and mem_ready (input, 1): a beat completes in any cycle where mem_ready=1 with mem_re or mem_we asserted.
REQ-013 SHALL have vwe (output, 1), vwaddr (output, VREG_AW), vwdata (output, VLEN): vector register-file write port.
REQ-014 SHALL have busy (output, 1), scalar_stall (output, 1), done (output, 1), misalign_err (output, 1).

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, WB.
REQ-016 In IDLE, a start with base_addr[1:0]==0 SHALL latch the operands, clear the beat counter and enter ACCESS on the next edge.
REQ-017 In IDLE, a start with base_addr[1:0]!=0 SHALL pulse misalign_err for one cycle, stay in IDLE and perform no memory access.
REQ-018 In ACCESS, beat k (0..VLEN/32-1) SHALL drive mem_addr = base + k*stride, mod 2^32 with wrap-around, and mem_mask = 32'hFFFFFFFF.
REQ-019 For VLD, mem_re SHALL be 1; on mem_ready, mem_rdata SHALL be stored into word k (bits 32k+31:32k) of the assembly buffer.
REQ-020 For VST, mem_we SHALL be 1 and mem_wdata SHALL be word k of the latched vs_data.
REQ-021 The beat counter SHALL advance only on mem_ready; with mem_ready=0 all outputs SHALL hold.
REQ-022 On completion of the last beat, VLD SHALL go to WB; VST SHALL go to IDLE and pulse done in the same cycle as that last mem_ready.
REQ-023 In WB (one cycle), vwe=1, vwaddr=vd and vwdata=buffer SHALL be driven together with done=1, followed by a return to IDLE.
REQ-024 Minimum latency from start to done with mem_ready held at 1: VLD = VLEN/32+1 cycles; VST = VLEN/32 cycles.
REQ-025 busy SHALL be 1 in ACCESS and WB and 0 in IDLE.
REQ-026 A start while busy SHALL be ignored; decode holds the instruction using busy.
REQ-027 In IDLE, the memory port SHALL be a combinational pass-through of the scalar request (mem_re = scalar_req & ~scalar_we, mem_we = scalar_req & scalar_we), and scalar_stall SHALL be 0.
REQ-028 While busy, scalar_stall SHALL equal scalar_req and the scalar request SHALL NOT reach memory.
REQ-029 When start and scalar_req arrive in the same IDLE cycle, the scalar request SHALL be served that cycle and the vector operation SHALL begin next cycle.
REQ-030 vwe, done and misalign_err SHALL be single-cycle pulses.

Reset
REQ-031 Assertion of rst_n=0 SHALL, asynchronously, set state=IDLE, beat counter=0, buffer=0, and drive busy, done, vwe and misalign_err to 0.
REQ-032 A reset mid-operation SHALL abort the operation with no vector register write; store words already written SHALL remain in memory.

Configuration
REQ-033 With VEC_STRIDE_EN defined, the stride port SHALL exist and REQ-018 SHALL use the latched stride; a stride of 0 SHALL access the same word on every beat.
REQ-034 Without VEC_STRIDE_EN, there SHALL be no stride port and the stride SHALL be the constant 4 (unit-stride).

Structure
REQ-035 The shared package vec_pkg SHALL hold the FSM state enum, VLEN_DEFAULT, WORD_BYTES=4 and the constant NBEATS = VLEN/32.
REQ-036 The address generator (base plus accumulated stride) SHALL be implemented as one sub-module, vec_addr_gen.

Verification
REQ-037 VLD, base=0x100, unit stride, mem_ready=1, memory words 0x11,0x22,0x33,0x44 -> after 5 cycles a vwe pulse with vwdata=0x00000044_00000033_00000022_00000011 and done.
REQ-038 VST, base=0x200, vs_data={0xD,0xC,0xB,0xA}, mem_ready toggling 1/0 -> writes 0xA@0x200, 0xB@0x204, 0xC@0x208, 0xD@0x20C; done pulses on the 4th write.
REQ-039 scalar_req during a VLD -> scalar_stall=1 for every busy cycle and no scalar access on the port; simultaneous start+scalar_req in IDLE -> scalar served first.
REQ-040 start with base=0x102 -> one misalign_err pulse, busy stays 0, no mem_re/mem_we.
REQ-041 rst_n low after beat 2 of a VLD -> IDLE immediately, no vwe; a subsequent VLD completes correctly.
REQ-042 (VEC_STRIDE_EN) base=0xFFFFFFF8, stride=8 -> addresses 0xFFFFFFF8, 0x0, 0x8, 0x10.

Source files
------------

// File: rtl/vec_pkg.sv
// vec_pkg: shared definitions for the vector memory sequencer.
//   VLEN_DEFAULT - default vector register width in bits
//   WORD_BYTES   - bytes per memory beat (also the unit stride)
//   NBEATS       - beats per vector at the default width
//   vec_state_e  - sequencer FSM states
//   nbeats_of()  - beats per vector for an arbitrary VLEN
package vec_pkg;

  localparam int unsigned VLEN_DEFAULT = 128;
  localparam int unsigned WORD_BYTES   = 4;
  localparam int unsigned NBEATS       = VLEN_DEFAULT / 32;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWb
  } vec_state_e;

  function automatic int unsigned nbeats_of(input int unsigned vlen);
    return vlen / 32;
  endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// vec_addr_gen: beat address generator for vector loads/stores.
// Holds the current beat address; loads base/stride at operation start and
// adds the latched stride each time a beat completes (mod 2^32).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - accept base/stride (operation start)
//   advance     - current beat completed, step to the next address
//   base        - first beat address
//   stride      - byte distance between beats
//   addr        - address of the current beat
module vec_addr_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] base,
  input  logic [31:0] stride,
  output logic [31:0] addr
);

  logic [31:0] addr_q;
  logic [31:0] stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr_q   <= base;
      stride_q <= stride;
    end else if (advance) begin
      addr_q   <= addr_q + stride_q;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: sequences a VLD/VST into VLEN/32 single-word beats on a
// data-memory port shared with the scalar LSU.
// Build option: define VEC_STRIDE_EN to add the stride input; otherwise the
// stride is fixed at 4 bytes (unit stride).
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   start, is_load, base_addr,
//   [stride,] vd, vs_data       - vector issue, sampled on an accepted start
//   scalar_*                    - scalar LSU request (pass-through when idle)
//   mem_*                       - shared data-memory port
//   vwe, vwaddr, vwdata         - vector register-file write port
//   busy                        - operation in flight (ACCESS or WB)
//   scalar_stall                - scalar request blocked while busy
//   done                        - one-cycle completion pulse
//   misalign_err                - one-cycle pulse, start with unaligned base
module vec_mem_sequencer
  import vec_pkg::*;
#(
  parameter int unsigned VLEN    = VLEN_DEFAULT,
  parameter int unsigned VREG_AW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_load,
  input  logic [31:0]        base_addr,
`ifdef VEC_STRIDE_EN
  input  logic [31:0]        stride,
`endif
  input  logic [VREG_AW-1:0] vd,
  input  logic [VLEN-1:0]    vs_data,
  input  logic               scalar_req,
  input  logic               scalar_we,
  input  logic [31:0]        scalar_addr,
  input  logic [31:0]        scalar_wdata,
  input  logic [31:0]        scalar_mask,
  output logic               mem_re,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic [31:0]        mem_mask,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ready,
  output logic               vwe,
  output logic [VREG_AW-1:0] vwaddr,
  output logic [VLEN-1:0]    vwdata,
  output logic               busy,
  output logic               scalar_stall,
  output logic               done,
  output logic               misalign_err
);

  localparam int unsigned NB = nbeats_of(VLEN);
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LastBeat = BW'(NB - 1);

  vec_state_e         st_q;
  logic [BW-1:0]      beat_q;
  logic               is_load_q;
  logic [VREG_AW-1:0] vd_q;
  logic [VLEN-1:0]    vs_q;
  logic [VLEN-1:0]    buf_q;
  logic               misalign_q;

  logic        start_ok;
  logic        start_bad;
  logic        beat_fire;
  logic        last_beat;
  logic [31:0] stride_eff;
  logic [31:0] vec_addr;

`ifdef VEC_STRIDE_EN
  assign stride_eff = stride;
`else
  assign stride_eff = 32'(WORD_BYTES);
`endif

  // A start while busy is ignored; only IDLE looks at it.
  assign start_ok  = (st_q == StIdle) && start && (base_addr[1:0] == 2'b00);
  assign start_bad = (st_q == StIdle) && start && (base_addr[1:0] != 2'b00);
  assign beat_fire = (st_q == StAccess) && mem_ready;
  assign last_beat = (beat_q == LastBeat);

  vec_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start_ok),
    .advance (beat_fire),
    .base    (base_addr),
    .stride  (stride_eff),
    .addr    (vec_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= StIdle;
      beat_q     <= '0;
      is_load_q  <= 1'b0;
      vd_q       <= '0;
      vs_q       <= '0;
      buf_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= start_bad;
      unique case (st_q)
        StIdle: begin
          if (start_ok) begin
            st_q      <= StAccess;
            beat_q    <= '0;
            is_load_q <= is_load;
            vd_q      <= vd;
            vs_q      <= vs_data;
          end
        end
        StAccess: begin
          if (mem_ready) begin
            if (is_load_q) begin
              buf_q[{beat_q, 5'd0} +: 32] <= mem_rdata;
            end
            if (last_beat) begin
              beat_q <= '0;
              st_q   <= is_load_q ? StWb : StIdle;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        StWb: begin
          st_q <= StIdle;
        end
        default: begin
          st_q <= StIdle;
        end
      endcase
    end
  end

  // Shared memory port: scalar pass-through when idle, vector beats in ACCESS,
  // nothing during the writeback cycle.
  always_comb begin
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_mask     = '0;
    scalar_stall = 1'b0;
    unique case (st_q)
      StIdle: begin
        mem_re    = scalar_req & ~scalar_we;
        mem_we    = scalar_req & scalar_we;
        mem_addr  = scalar_addr;
        mem_wdata = scalar_wdata;
        mem_mask  = scalar_mask;
      end
      StAccess: begin
        mem_re       = is_load_q;
        mem_we       = ~is_load_q;
        mem_addr     = vec_addr;
        mem_wdata    = vs_q[{beat_q, 5'd0} +: 32];
        mem_mask     = 32'hFFFF_FFFF;
        scalar_stall = scalar_req;
      end
      StWb: begin
        scalar_stall = scalar_req;
      end
      default: begin
        scalar_stall = scalar_req;
      end
    endcase
  end

  assign busy         = (st_q != StIdle);
  assign vwe          = (st_q == StWb);
  assign vwaddr       = vd_q;
  assign vwdata       = buf_q;
  assign misalign_err = misalign_q;
  // Stores finish in the cycle of the last accepted beat; loads one cycle later in WB.
  assign done = (st_q == StWb) ||
                ((st_q == StAccess) && !is_load_q && mem_ready && last_beat);

endmodule

// File: tb/tb_vec_mem_sequencer.sv
module tb_vec_mem_sequencer;

  localparam int unsigned VLEN    = 128;
  localparam int unsigned VREG_AW = 5;
  localparam int unsigned NB      = VLEN / 32;
`ifdef VEC_STRIDE_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               is_load = 1'b0;
  logic [31:0]        base_addr = '0;
  logic [VREG_AW-1:0] vd = '0;
  logic [VLEN-1:0]    vs_data = '0;
  logic               scalar_req = 1'b0;
  logic               scalar_we = 1'b0;
  logic [31:0]        scalar_addr = '0;
  logic [31:0]        scalar_wdata = '0;
  logic [31:0]        scalar_mask = '0;
  logic               mem_re, mem_we;
  logic [31:0]        mem_addr, mem_wdata, mem_mask;
  logic [31:0]        mem_rdata = '0;
  logic               mem_ready = 1'b0;
  logic               vwe;
  logic [VREG_AW-1:0] vwaddr;
  logic [VLEN-1:0]    vwdata;
  logic               busy, scalar_stall, done, misalign_err;

  // Stride the bench intends for the next operation (constant 4 when the option is off).
  logic [31:0] st_cfg = 32'd4;
`ifdef VEC_STRIDE_EN
  logic [31:0] stride;
  assign stride = st_cfg;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_mem_sequencer #(.VLEN(VLEN), .VREG_AW(VREG_AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_load      (is_load),
    .base_addr    (base_addr),
`ifdef VEC_STRIDE_EN
    .stride       (stride),
`endif
    .vd           (vd),
    .vs_data      (vs_data),
    .scalar_req   (scalar_req),
    .scalar_we    (scalar_we),
    .scalar_addr  (scalar_addr),
    .scalar_wdata (scalar_wdata),
    .scalar_mask  (scalar_mask),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_mask     (mem_mask),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .vwe          (vwe),
    .vwaddr       (vwaddr),
    .vwdata       (vwdata),
    .busy         (busy),
    .scalar_stall (scalar_stall),
    .done         (done),
    .misalign_err (misalign_err)
  );

  // Behavioural word memory; unwritten words read as a hash of their address.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready) mem[mem_addr] = mem_wdata;
    mem_rdata = mem_rd(mem_addr);
  end

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 1;
    return $urandom_range(0, 9) < 6;
  endfunction

  function automatic logic [VLEN-1:0] exp_load(input logic [31:0] base, input logic [31:0] st);
    logic [VLEN-1:0] v;
    v = '0;
    for (int k = 0; k < NB; k++) v[k*32 +: 32] = mem_rd(base + 32'(k) * st);
    return v;
  endfunction

  // Observations of one vector operation.
  logic [31:0]        obs_addr[$];
  logic [31:0]        obs_wdata[$];
  int                 obs_nwb, obs_lat, obs_mask_bad, obs_vwe_done;
  bit                 obs_done;
  logic [VLEN-1:0]    obs_wb_data;
  logic [VREG_AW-1:0] obs_wb_vd;

  task automatic run_vec(input bit ld, input logic [31:0] base, input logic [VREG_AW-1:0] v,
                         input logic [VLEN-1:0] src, input int mode);
    int cyc;
    obs_addr.delete();
    obs_wdata.delete();
    obs_nwb = 0; obs_lat = -1; obs_mask_bad = 0; obs_vwe_done = 0; obs_done = 0;
    obs_wb_data = '0; obs_wb_vd = '0;
    @(posedge clk); #1;
    start = 1'b1; is_load = ld; base_addr = base; vd = v; vs_data = src;
    mem_ready = ready_for(mode, 0);
    cyc = 0;
    while (!obs_done && cyc <= 200) begin
      @(negedge clk);
      if (busy && mem_ready && (mem_re || mem_we)) begin
        obs_addr.push_back(mem_addr);
        obs_wdata.push_back(mem_wdata);
      end
      if (busy && (mem_re || mem_we) && mem_mask !== 32'hFFFF_FFFF) obs_mask_bad++;
      if (vwe) begin obs_nwb++; obs_wb_data = vwdata; obs_wb_vd = vwaddr; end
      if (vwe && done) obs_vwe_done++;
      if (done) begin obs_done = 1'b1; obs_lat = cyc; end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      mem_ready = ready_for(mode, cyc);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({done, vwe, misalign_err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b exp 000", {done, vwe, misalign_err}); end
    checks++; if ({mem_re, mem_we, scalar_stall} !== 3'b000) begin
      errors++; $display("FAIL reset_port got %b exp 000", {mem_re, mem_we, scalar_stall}); end
    checks++; if (vwdata !== '0) begin errors++; $display("FAIL reset_buffer got %h exp 0", vwdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_vld_basic;
    mem[32'h100] = 32'h11; mem[32'h104] = 32'h22; mem[32'h108] = 32'h33; mem[32'h10C] = 32'h44;
    st_cfg = 32'd4;
    run_vec(1'b1, 32'h100, 5'd7, '0, 0);
    checks++; if (obs_done !== 1'b1 || obs_lat != NB + 1) begin
      errors++; $display("FAIL vld_latency got %0d exp %0d", obs_lat, NB + 1); end
    checks++; if (obs_nwb != 1 || obs_vwe_done != 1) begin
      errors++; $display("FAIL vld_vwe got %0d/%0d exp 1/1", obs_nwb, obs_vwe_done); end
    checks++; if (obs_wb_data !== 128'h00000044_00000033_00000022_00000011) begin
      errors++; $display("FAIL vld_data got %h exp 00000044000000330000002200000011", obs_wb_data); end
    checks++; if (obs_wb_vd !== 5'd7) begin errors++; $display("FAIL vld_vd got %0d exp 7", obs_wb_vd); end
    @(negedge clk);
    checks++; if ({busy, done, vwe} !== 3'b000) begin
      errors++; $display("FAIL vld_pulse_end got %b exp 000", {busy, done, vwe}); end
  endtask

  task automatic test_vst_toggle;
    logic [31:0] exp_w[4];
    exp_w = '{32'hA, 32'hB, 32'hC, 32'hD};
    st_cfg = 32'd4;
    run_vec(1'b0, 32'h200, 5'd0, {32'hD, 32'hC, 32'hB, 32'hA}, 1);
    checks++; if (obs_addr.size() != NB) begin
      errors++; $display("FAIL vst_beats got %0d exp %0d", obs_addr.size(), NB); end
    for (int k = 0; k < NB && k < obs_addr.size(); k++) begin
      checks++; if (obs_addr[k] !== 32'h200 + 32'(k) * 4 || obs_wdata[k] !== exp_w[k]) begin
        errors++; $display("FAIL vst_write%0d got %h@%h exp %h@%h", k, obs_wdata[k], obs_addr[k],
                           exp_w[k], 32'h200 + 32'(k) * 4); end
    end
    // Ready is high on odd cycles, so the 4th write lands in cycle 7.
    checks++; if (obs_lat != 2 * NB - 1) begin
      errors++; $display("FAIL vst_done_cycle got %0d exp %0d", obs_lat, 2 * NB - 1); end
    checks++; if (obs_nwb != 0) begin errors++; $display("FAIL vst_no_vwe got %0d exp 0", obs_nwb); end
    checks++; if (mem_rd(32'h20C) !== 32'hD || mem_rd(32'h200) !== 32'hA) begin
      errors++; $display("FAIL vst_mem got %h,%h exp a,d", mem_rd(32'h200), mem_rd(32'h20C)); end
  endtask

  task automatic test_back_to_back;
    logic [VLEN-1:0] src;
    for (int k = 0; k < NB; k++) src[k*32 +: 32] = $urandom();
    st_cfg = 32'd4;
    run_vec(1'b0, 32'h800, 5'd0, src, 0);
    checks++; if (obs_lat != NB) begin errors++; $display("FAIL b2b_vst_lat got %0d exp %0d", obs_lat, NB); end
    run_vec(1'b1, 32'h800, 5'd3, '0, 0);
    checks++; if (obs_lat != NB + 1) begin
      errors++; $display("FAIL b2b_vld_lat got %0d exp %0d", obs_lat, NB + 1); end
    checks++; if (obs_wb_data !== src) begin
      errors++; $display("FAIL b2b_roundtrip got %h exp %h", obs_wb_data, src); end
  endtask

  task automatic test_scalar;
    int nbusy = 0, bad = 0, nwb = 0;
    logic [VLEN-1:0] exp, got;
    st_cfg = 32'd4;
    exp = exp_load(32'h300, 32'd4);
    got = '0;
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b1; base_addr = 32'h300; vd = 5'd9; mem_ready = 1'b1;
    scalar_req = 1'b1; scalar_we = 1'b0; scalar_addr = 32'h4000_0000; scalar_mask = 32'h0000_00FF;
    @(negedge clk);
    checks++; if ({mem_re, mem_we, scalar_stall, busy} !== 4'b1000 || mem_addr !== 32'h4000_0000 ||
                  mem_mask !== 32'h0000_00FF) begin
      errors++; $display("FAIL scalar_first got re/we/stall/busy %b addr %h exp 1000 40000000",
                         {mem_re, mem_we, scalar_stall, busy}, mem_addr); end
    @(posedge clk); #1;
    start = 1'b0; scalar_we = 1'b1; scalar_addr = 32'h5000_0000; scalar_wdata = 32'hCAFE_F00D;
    for (int c = 0; c < NB + 3; c++) begin
      @(negedge clk);
      if (busy) begin
        nbusy++;
        if (scalar_stall !== 1'b1 || mem_we !== 1'b0 || mem_addr === 32'h5000_0000) bad++;
      end
      if (vwe) begin nwb++; got = vwdata; end
      if (!busy) break;
      @(posedge clk); #1;
    end
    checks++; if (nbusy != NB + 1) begin errors++; $display("FAIL scalar_busy_cycles got %0d exp %0d", nbusy, NB + 1); end
    checks++; if (bad != 0) begin errors++; $display("FAIL scalar_blocked got %0d leaks exp 0", bad); end
    checks++; if (nwb != 1 || got !== exp) begin
      errors++; $display("FAIL scalar_vld_data got %h exp %h", got, exp); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h5000_0000 || scalar_stall !== 1'b0) begin
      errors++; $display("FAIL scalar_resume got we %b addr %h exp 1 50000000", mem_we, mem_addr); end
    @(posedge clk); #1;
    scalar_req = 1'b0; scalar_we = 1'b0;
  endtask

  task automatic test_misalign;
    logic [31:0] bases[2];
    int pulses, nbusy, nacc;
    bases = '{32'h102, 32'h201};
    for (int i = 0; i < 2; i++) begin
      pulses = 0; nbusy = 0; nacc = 0;
      @(posedge clk); #1;
      start = 1'b1; is_load = (i == 0); base_addr = bases[i]; mem_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (misalign_err) pulses++;
        if (busy) nbusy++;
        if (mem_re || mem_we) nacc++;
        @(posedge clk); #1;
        start = 1'b0;
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL misalign_pulse%0d got %0d exp 1", i, pulses); end
      checks++; if (nbusy != 0 || nacc != 0) begin
        errors++; $display("FAIL misalign_quiet%0d got busy %0d acc %0d exp 0 0", i, nbusy, nacc); end
    end
  endtask

  task automatic test_busy_start;
    logic [VLEN-1:0] exp;
    int nwb = 0, nbeat = 0, badaddr = 0;
    logic [VREG_AW-1:0] wvd;
    st_cfg = 32'd4;
    exp = exp_load(32'h600, 32'd4);
    wvd = '0;
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b1; base_addr = 32'h600; vd = 5'd4; mem_ready = 1'b1;
    for (int c = 0; c < NB + 4; c++) begin
      @(negedge clk);
      if (busy && mem_ready && (mem_re || mem_we)) begin
        if (mem_addr !== 32'h600 + 32'(nbeat) * 4 || mem_we) badaddr++;
        nbeat++;
      end
      if (vwe) begin nwb++; wvd = vwaddr; if (vwdata !== exp) badaddr++; end
      @(posedge clk); #1;
      // Keep start asserted with different operands while the first op is busy.
      if (c == 0) begin base_addr = 32'h700; vd = 5'd17; is_load = 1'b0; end
      if (c == 2) start = 1'b0;
    end
    checks++; if (nbeat != NB || badaddr != 0) begin
      errors++; $display("FAIL busy_start_beats got %0d beats %0d bad exp %0d 0", nbeat, badaddr, NB); end
    checks++; if (nwb != 1 || wvd !== 5'd4) begin
      errors++; $display("FAIL busy_start_vwe got %0d vd %0d exp 1 vd 4", nwb, wvd); end
  endtask

  task automatic test_wrap;
    logic [VLEN-1:0] exp;
    st_cfg = STRIDE_EN ? 32'd8 : 32'd4;
    exp = exp_load(32'hFFFF_FFF8, st_cfg);
    run_vec(1'b1, 32'hFFFF_FFF8, 5'd1, '0, 0);
    checks++; if (obs_addr.size() != NB) begin
      errors++; $display("FAIL wrap_beats got %0d exp %0d", obs_addr.size(), NB); end
    for (int k = 0; k < NB && k < obs_addr.size(); k++) begin
      checks++; if (obs_addr[k] !== 32'hFFFF_FFF8 + 32'(k) * st_cfg) begin
        errors++; $display("FAIL wrap_addr%0d got %h exp %h", k, obs_addr[k], 32'hFFFF_FFF8 + 32'(k) * st_cfg); end
    end
    checks++; if (obs_wb_data !== exp) begin errors++; $display("FAIL wrap_data got %h exp %h", obs_wb_data, exp); end
  endtask

  task automatic test_reset_mid;
    logic [VLEN-1:0] exp;
    int nwb = 0;
    st_cfg = 32'd4;
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b1; base_addr = 32'h400; vd = 5'd2; mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);  // beats 0 and 1 complete
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, vwe, done, mem_re, mem_we} !== 5'b00000) begin
      errors++; $display("FAIL reset_mid_abort got %b exp 00000", {busy, vwe, done, mem_re, mem_we}); end
    checks++; if (vwdata !== '0) begin errors++; $display("FAIL reset_mid_buffer got %h exp 0", vwdata); end
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (vwe) nwb++; end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (vwe || busy) nwb++; end
    checks++; if (nwb != 0) begin errors++; $display("FAIL reset_mid_no_vwe got %0d exp 0", nwb); end
    exp = exp_load(32'h500, 32'd4);
    run_vec(1'b1, 32'h500, 5'd6, '0, 0);
    checks++; if (obs_nwb != 1 || obs_wb_data !== exp || obs_wb_vd !== 5'd6) begin
      errors++; $display("FAIL reset_mid_next got %h vd %0d exp %h vd 6", obs_wb_data, obs_wb_vd, exp); end
  endtask

  task automatic test_random;
    logic [31:0] base, strides[5];
    logic [VLEN-1:0] src, exp;
    logic [VREG_AW-1:0] v;
    bit ld;
    int abad, dbad;
    for (int n = 0; n < 24; n++) begin
      ld = $urandom_range(0, 1);
      base = $urandom() & 32'hFFFF_FFFC;
      strides = '{32'd0, 32'd4, 32'd8, 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC};
      st_cfg = STRIDE_EN ? strides[$urandom_range(0, 4)] : 32'd4;
      v = VREG_AW'($urandom());
      for (int k = 0; k < NB; k++) src[k*32 +: 32] = $urandom();
      exp = exp_load(base, st_cfg);
      run_vec(ld, base, v, src, 2);
      checks++; if (!obs_done || obs_addr.size() != NB) begin
        errors++; $display("FAIL rand%0d_beats got done %0d beats %0d exp 1 %0d", n, obs_done,
                           obs_addr.size(), NB); end
      abad = 0; dbad = 0;
      for (int k = 0; k < NB && k < obs_addr.size(); k++) begin
        if (obs_addr[k] !== base + 32'(k) * st_cfg) abad++;
        if (!ld && obs_wdata[k] !== src[k*32 +: 32]) dbad++;
      end
      checks++; if (abad != 0 || dbad != 0 || obs_mask_bad != 0) begin
        errors++; $display("FAIL rand%0d_beats_content got addr %0d data %0d mask %0d bad exp 0",
                           n, abad, dbad, obs_mask_bad); end
      if (ld) begin
        checks++; if (obs_nwb != 1 || obs_vwe_done != 1 || obs_wb_data !== exp || obs_wb_vd !== v) begin
          errors++; $display("FAIL rand%0d_vld got %h vd %0d exp %h vd %0d", n, obs_wb_data, obs_wb_vd, exp, v); end
      end else begin
        checks++; if (obs_nwb != 0) begin errors++; $display("FAIL rand%0d_vst_vwe got %0d exp 0", n, obs_nwb); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vld_basic();
    test_vst_toggle();
    test_back_to_back();
    test_scalar();
    test_misalign();
    test_busy_start();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
